// File: rtl/ppu_bus_master.sv
// CPU-side initiator for the PPU register port: one read/write request at a time
// becomes a chip-select bus cycle on a shared tristate data bus.
module ppu_bus_master #(
  parameter int unsigned CS_LOW_CYCLES  = 4,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic       resp_rw,
  output logic [7:0] resp_rdata,
  output logic [2:0] ppu_addr,
  output logic       ppu_rw,
  output logic       ppu_cs,
  inout  wire  [7:0] ppuData_IN_OUT
);

  if (CS_LOW_CYCLES < 3) begin : g_bad_low
    $error("ppu_bus_master: CS_LOW_CYCLES must be at least 3");
  end
  if (CS_HIGH_CYCLES < 2) begin : g_bad_high
    $error("ppu_bus_master: CS_HIGH_CYCLES must be at least 2");
  end

  localparam int unsigned CNT_MAX = (CS_LOW_CYCLES > CS_HIGH_CYCLES) ? CS_LOW_CYCLES : CS_HIGH_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(CS_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(CS_HIGH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cap_rw;
  logic [2:0]    cap_addr;
  logic [7:0]    cap_wdata;
  logic          drive_en;
  logic          accept;
  logic          last_access;
  logic          rw_eff;
  logic          drive_n;

  assign accept      = (state == IDLE) && req_valid;
  assign last_access = (state == ACCESS) && (cnt == '0);
  assign rw_eff      = accept ? req_rw : cap_rw;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE:    if (req_valid) state_n = SETUP;
      SETUP: begin
        state_n = ACCESS;
        cnt_n   = LOW_LOAD;
      end
      ACCESS:
        if (cnt == '0) begin
          state_n = RECOVER;
          cnt_n   = HIGH_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      RECOVER:
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // Bus enable is decided from the next state so the pins stay registered.
  assign drive_n = ((state_n == SETUP) || (state_n == ACCESS)) && !rw_eff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_rw    <= 1'b1;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        cap_rw    <= req_rw;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ppu_cs     <= 1'b1;
      ppu_rw     <= 1'b1;
      ppu_addr   <= '0;
      drive_en   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rw    <= 1'b1;
      resp_rdata <= '0;
    end else begin
      ppu_cs     <= (state_n != ACCESS);
      drive_en   <= drive_n;
      req_ready  <= (state_n == IDLE);
      resp_valid <= last_access;
      if (accept) begin
        ppu_addr <= req_addr;
        ppu_rw   <= req_rw;
      end
      if (last_access) begin
        resp_rw <= cap_rw;
        if (cap_rw) resp_rdata <= ppuData_IN_OUT;
      end
    end
  end

  assign ppuData_IN_OUT = drive_en ? cap_wdata : 'z;

  logic unused_addr;
  assign unused_addr = ^cap_addr;

endmodule
